mux_2x1_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares the 2:1 data mux between two requesters.
- Owns the mux select and grants one requester at a time.
- Forwards the granted requester's data downstream with a valid/ready handshake.
- Sits between two producer blocks and a single consumer port.

---
 rtl/mux_2x1_rr_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/mux_2x1_rr_arbiter.sv
// mux_2x1_rr_arbiter: round-robin owner of a shared 2:1 data mux with valid/ready output.
// Defining BURST_LIMIT_EN caps a contested grant at MAX_BURST beats.
module mux_2x1_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] din0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt1,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic              sel,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_n, other;
  logic last, last_n, own0, own1, req_x, req_o, gnt_x, limit;
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST out of range");
  end
  assign own0      = state == OWN0;
  assign own1      = state == OWN1;
  assign sel       = own1;
  assign dout      = sel ? din1 : din0;
  assign out_valid = (own0 & req0) | (own1 & req1);
  assign gnt0      = own0 & req0 & out_ready;
  assign gnt1      = own1 & req1 & out_ready;
  assign busy      = state != IDLE;
  assign req_x     = own1 ? req1 : req0;
  assign req_o     = own1 ? req0 : req1;
  assign gnt_x     = gnt0 | gnt1;
  assign other     = own1 ? OWN0 : OWN1;
`ifdef BURST_LIMIT_EN
  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);
  logic [7:0] cnt, cnt_n;
  assign limit = gnt_x & req_o & (cnt == CNT_MAX);
  // Any change of state starts a fresh burst; a lone owner saturates instead of wrapping.
  assign cnt_n = (state_n != state) ? 8'd0 : (gnt_x && cnt != CNT_MAX) ? cnt + 8'd1 : cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= 8'd0;
    else cnt <= cnt_n;
`else
  assign limit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    last_n  = last;
    if (state == IDLE)
      state_n = (req0 & req1) ? (last ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (!req_x || limit) begin
      last_n  = own1;
      state_n = req_o ? other : IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      last  <= last_n;
    end
endmodule
